// File: rtl/csoc_uart_responder.sv
// csoc_uart_responder
//   CSoC-side end of the tester byte interface. Bytes strobed in by the tester
//   (host_read/host_data) are buffered in an RX FIFO for the core. Bytes from
//   the core are buffered in a TX FIFO and returned to the tester as timed
//   dev_write strobes, each as SETUP (1 cycle), STROBE (STROBE_CYCLES) and
//   GAP (GAP_CYCLES).
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   host_read, host_data         tester -> RX FIFO, one byte per high cycle
//   dev_write, dev_data          TX strobe and byte to the tester
//   core_rx_data/valid/ready     RX FIFO head towards the core
//   core_tx_data/valid/ready     core -> TX FIFO push interface
//   rx_overflow                  sticky flag, an RX byte was dropped (full)
//   loopback                     only with CSOC_RESP_LOOPBACK_EN: echo RX to TX
//
// Optional feature macro: CSOC_RESP_LOOPBACK_EN
module csoc_uart_responder #(
    parameter int unsigned RX_DEPTH      = 4,
    parameter int unsigned TX_DEPTH      = 4,
    parameter int unsigned STROBE_CYCLES = 2,
    parameter int unsigned GAP_CYCLES    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       host_read,
    input  logic [7:0] host_data,
`ifdef CSOC_RESP_LOOPBACK_EN
    input  logic       loopback,
`endif
    output logic       dev_write,
    output logic [7:0] dev_data,
    output logic [7:0] core_rx_data,
    output logic       core_rx_valid,
    input  logic       core_rx_ready,
    input  logic [7:0] core_tx_data,
    input  logic       core_tx_valid,
    output logic       core_tx_ready,
    output logic       rx_overflow
);

    localparam int unsigned RxAw   = $clog2(RX_DEPTH);
    localparam int unsigned TxAw   = $clog2(TX_DEPTH);
    localparam int unsigned CntMax = (STROBE_CYCLES > GAP_CYCLES) ? STROBE_CYCLES : GAP_CYCLES;
    localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;

    typedef enum logic [1:0] {StIdle, StSetup, StStrobe, StGap} state_e;

    // ---------------------------------------------------------------- RX FIFO
    logic [7:0]    r_rx_mem [RX_DEPTH];
    logic [RxAw-1:0] r_rx_wr, r_rx_rd;
    logic [RxAw:0] r_rx_cnt, w_rx_cnt_next;
    logic          r_rx_ovf;
    logic          w_rx_full, w_rx_pop, w_rx_push;

    assign w_rx_full     = (r_rx_cnt == (RxAw + 1)'(RX_DEPTH));
    assign core_rx_valid = (r_rx_cnt != '0);
    assign w_rx_pop      = core_rx_valid & core_rx_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign w_rx_push     = host_read & (~w_rx_full | w_rx_pop);
    assign core_rx_data  = r_rx_mem[r_rx_rd];
    assign rx_overflow   = r_rx_ovf;

    always_comb begin
        w_rx_cnt_next = r_rx_cnt;
        case ({w_rx_push, w_rx_pop})
            2'b10:   w_rx_cnt_next = r_rx_cnt + (RxAw + 1)'(1);
            2'b01:   w_rx_cnt_next = r_rx_cnt - (RxAw + 1)'(1);
            default: w_rx_cnt_next = r_rx_cnt;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < RX_DEPTH; i++) r_rx_mem[i] <= '0;
            r_rx_wr  <= '0;
            r_rx_rd  <= '0;
            r_rx_cnt <= '0;
            r_rx_ovf <= 1'b0;
        end else begin
            if (w_rx_push) begin
                r_rx_mem[r_rx_wr] <= host_data;
                r_rx_wr           <= r_rx_wr + RxAw'(1);
            end
            if (w_rx_pop) r_rx_rd <= r_rx_rd + RxAw'(1);
            if (host_read && !w_rx_push) r_rx_ovf <= 1'b1;
            r_rx_cnt <= w_rx_cnt_next;
        end
    end

    // ---------------------------------------------------------------- TX FIFO
    logic [7:0]    r_tx_mem [TX_DEPTH];
    logic [TxAw-1:0] r_tx_wr, r_tx_rd;
    logic [TxAw:0] r_tx_cnt, w_tx_cnt_next;
    logic          w_tx_full, w_tx_pop, w_tx_push;
    logic [7:0]    w_tx_wdata;

    assign w_tx_full = (r_tx_cnt == (TxAw + 1)'(TX_DEPTH));

`ifdef CSOC_RESP_LOOPBACK_EN
    logic w_lb_push;
    assign w_lb_push     = loopback & w_rx_push & ~w_tx_full;
    // The echo path owns the TX write port whenever the tester is strobing.
    assign core_tx_ready = ~w_tx_full & ~(loopback & host_read);
    assign w_tx_push     = w_lb_push | (core_tx_valid & core_tx_ready);
    assign w_tx_wdata    = w_lb_push ? host_data : core_tx_data;
`else
    assign core_tx_ready = ~w_tx_full;
    assign w_tx_push     = core_tx_valid & core_tx_ready;
    assign w_tx_wdata    = core_tx_data;
`endif

    always_comb begin
        w_tx_cnt_next = r_tx_cnt;
        case ({w_tx_push, w_tx_pop})
            2'b10:   w_tx_cnt_next = r_tx_cnt + (TxAw + 1)'(1);
            2'b01:   w_tx_cnt_next = r_tx_cnt - (TxAw + 1)'(1);
            default: w_tx_cnt_next = r_tx_cnt;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < TX_DEPTH; i++) r_tx_mem[i] <= '0;
            r_tx_wr  <= '0;
            r_tx_rd  <= '0;
            r_tx_cnt <= '0;
        end else begin
            if (w_tx_push) begin
                r_tx_mem[r_tx_wr] <= w_tx_wdata;
                r_tx_wr           <= r_tx_wr + TxAw'(1);
            end
            if (w_tx_pop) r_tx_rd <= r_tx_rd + TxAw'(1);
            r_tx_cnt <= w_tx_cnt_next;
        end
    end

    // ----------------------------------------------------------------- TX FSM
    state_e          r_state, w_state_next;
    logic [CntW-1:0] r_cnt, w_cnt_next;
    logic [7:0]      r_dev_data;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_tx_pop     = 1'b0;
        case (r_state)
            StIdle: begin
                if (r_tx_cnt != '0) begin
                    w_tx_pop     = 1'b1;
                    w_state_next = StSetup;
                end
            end
            StSetup: begin
                w_state_next = StStrobe;
                w_cnt_next   = CntW'(STROBE_CYCLES - 1);
            end
            StStrobe: begin
                if (r_cnt == '0) begin
                    if (GAP_CYCLES > 0) begin
                        w_state_next = StGap;
                        w_cnt_next   = CntW'(GAP_CYCLES - 1);
                    end else begin
                        w_state_next = StIdle;
                    end
                end else begin
                    w_cnt_next = r_cnt - CntW'(1);
                end
            end
            StGap: begin
                if (r_cnt == '0) w_state_next = StIdle;
                else             w_cnt_next   = r_cnt - CntW'(1);
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= StIdle;
            r_cnt      <= '0;
            r_dev_data <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (w_tx_pop) r_dev_data <= r_tx_mem[r_tx_rd];
        end
    end

    // Decoded from state so an async reset drops the strobe immediately.
    assign dev_write = (r_state == StStrobe);
    assign dev_data  = r_dev_data;

endmodule

// File: tb/tb_csoc_uart_responder.sv
// Bench for csoc_uart_responder: a queue-based model checked every cycle on
// the falling edge, plus directed scenarios with literal expectations.
module tb_csoc_uart_responder;

    localparam int RXD = 4;
    localparam int TXD = 4;
    localparam int S   = 2;
    localparam int G   = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       host_read = 1'b0;
    logic [7:0] host_data = 8'h00;
    logic       dev_write;
    logic [7:0] dev_data;
    logic [7:0] core_rx_data;
    logic       core_rx_valid;
    logic       core_rx_ready = 1'b0;
    logic [7:0] core_tx_data = 8'h00;
    logic       core_tx_valid = 1'b0;
    logic       core_tx_ready;
    logic       rx_overflow;
`ifdef CSOC_RESP_LOOPBACK_EN
    logic       loopback = 1'b0;
`endif

    csoc_uart_responder #(
        .RX_DEPTH      (RXD),
        .TX_DEPTH      (TXD),
        .STROBE_CYCLES (S),
        .GAP_CYCLES    (G)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .host_read     (host_read),
        .host_data     (host_data),
`ifdef CSOC_RESP_LOOPBACK_EN
        .loopback      (loopback),
`endif
        .dev_write     (dev_write),
        .dev_data      (dev_data),
        .core_rx_data  (core_rx_data),
        .core_rx_valid (core_rx_valid),
        .core_rx_ready (core_rx_ready),
        .core_tx_data  (core_tx_data),
        .core_tx_valid (core_tx_valid),
        .core_tx_ready (core_tx_ready),
        .rx_overflow   (rx_overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------ model
    logic [7:0] rx_q[$];
    logic [7:0] tx_q[$];
    logic [7:0] m_dev_data = 8'h00;
    logic       m_ovf = 1'b0;
    int         m_take = -1000;  // cycle in which the current byte left the TX queue
    int         cyc = 0;
    int         rx_sz0, tx_sz0;
    logic       m_rx_pop, m_rx_acc, m_ready, m_wr, lb_on;

    // strobe monitor
    logic [7:0] seen_q[$];
    int         seen_cyc[$];
    int         seen_len[$];
    logic       prev_wr = 1'b0;
    int         run_len = 0;

    always @(negedge clk) begin
        if (rst) begin
            rx_q.delete();
            tx_q.delete();
            m_ovf      = 1'b0;
            m_dev_data = 8'h00;
            m_take     = -1000;
        end
`ifdef CSOC_RESP_LOOPBACK_EN
        lb_on = loopback;
`else
        lb_on = 1'b0;
`endif
        // A byte taken in cycle T is set up in T+1 and strobed in T+2..T+1+S.
        m_wr    = (cyc >= m_take + 2) && (cyc < m_take + 2 + S);
        m_ready = (tx_q.size() < TXD) && !(lb_on && host_read);
        check("dev_write", dev_write, m_wr);
        check("dev_data", dev_data, m_dev_data);
        check("core_rx_valid", core_rx_valid, rx_q.size() > 0);
        if (rx_q.size() > 0) check("core_rx_data", core_rx_data, rx_q[0]);
        check("core_tx_ready", core_tx_ready, m_ready);
        check("rx_overflow", rx_overflow, m_ovf);

        if (dev_write && !prev_wr) begin
            seen_q.push_back(dev_data);
            seen_cyc.push_back(cyc);
        end
        if (dev_write) run_len++;
        if (!dev_write && prev_wr) begin
            seen_len.push_back(run_len);
            run_len = 0;
        end
        prev_wr = dev_write;

        if (!rst) begin
            rx_sz0   = rx_q.size();
            tx_sz0   = tx_q.size();
            m_rx_pop = (rx_sz0 > 0) && core_rx_ready;
            m_rx_acc = host_read && ((rx_sz0 < RXD) || m_rx_pop);
            if (m_rx_pop) void'(rx_q.pop_front());
            if (m_rx_acc) rx_q.push_back(host_data);
            else if (host_read) m_ovf = 1'b1;
            if ((cyc >= m_take + 2 + S + G) && (tx_sz0 > 0)) begin
                m_dev_data = tx_q.pop_front();
                m_take     = cyc;
            end
            if (core_tx_valid && m_ready) tx_q.push_back(core_tx_data);
            if (lb_on && m_rx_acc && (tx_sz0 < TXD)) tx_q.push_back(host_data);
        end
        cyc++;
    end

    // -------------------------------------------------------------- stimulus
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_tx(input logic [7:0] b);
        int k = 0;
        core_tx_valid = 1'b1;
        core_tx_data  = b;
        while (!core_tx_ready && k < 40) begin
            tick();
            k++;
        end
        check("push_tx_timeout", k < 40, 1'b1);
        tick();
        core_tx_valid = 1'b0;
    endtask

    task automatic wait_seen(input int n, input string name);
        int k = 0;
        while ((seen_q.size() < n || seen_len.size() < n) && k < 100) begin
            tick();
            k++;
        end
        check(name, (seen_q.size() >= n) && (seen_len.size() >= n), 1'b1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tick();
        tick();
        // reset state
        check("rst_dev_write", dev_write, 1'b0);
        check("rst_dev_data", dev_data, 8'h00);
        check("rst_rx_valid", core_rx_valid, 1'b0);
        check("rst_rx_data", core_rx_data, 8'h00);
        check("rst_tx_ready", core_tx_ready, 1'b1);
        check("rst_overflow", rx_overflow, 1'b0);
        rst = 1'b0;
        tick();

        // RX basic
        host_read = 1'b1;
        host_data = 8'hA5;
        tick();
        host_read = 1'b0;
        check("rx_basic_valid", core_rx_valid, 1'b1);
        check("rx_basic_data", core_rx_data, 8'hA5);
        core_rx_ready = 1'b1;
        tick();
        core_rx_ready = 1'b0;
        check("rx_basic_popped", core_rx_valid, 1'b0);

        // RX full with simultaneous pop: push accepted, no overflow
        for (int i = 0; i < 4; i++) begin
            host_read = 1'b1;
            host_data = 8'(8'h11 + i);
            tick();
        end
        host_data     = 8'h15;
        core_rx_ready = 1'b1;
        tick();
        host_read = 1'b0;
        core_rx_ready = 1'b0;
        check("rx_full_pop_no_ovf", rx_overflow, 1'b0);
        core_rx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("rx_full_pop_data", core_rx_data, 8'(8'h12 + i));
            tick();
        end
        core_rx_ready = 1'b0;
        check("rx_full_pop_empty", core_rx_valid, 1'b0);

        // RX overflow
        for (int i = 1; i <= 5; i++) begin
            host_read = 1'b1;
            host_data = 8'(i);
            tick();
        end
        host_read = 1'b0;
        check("rx_ovf_flag", rx_overflow, 1'b1);
        core_rx_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check("rx_ovf_data", core_rx_data, 8'(i));
            tick();
        end
        core_rx_ready = 1'b0;
        check("rx_ovf_drained", core_rx_valid, 1'b0);
        check("rx_ovf_sticky", rx_overflow, 1'b1);

        // TX timing
        seen_q.delete();
        seen_cyc.delete();
        seen_len.delete();
        core_tx_valid = 1'b1;
        core_tx_data  = 8'h3C;
        tick();
        core_tx_data = 8'hC3;
        tick();
        core_tx_valid = 1'b0;
        wait_seen(2, "tx_timing_wait");
        if (seen_q.size() >= 2 && seen_len.size() >= 2) begin
            check("tx_byte0", seen_q[0], 8'h3C);
            check("tx_len0", seen_len[0], 2);
            check("tx_byte1", seen_q[1], 8'hC3);
            check("tx_period", seen_cyc[1] - seen_cyc[0], 5);
        end
        repeat (3) tick();

        // TX full while FSM busy
        seen_q.delete();
        seen_cyc.delete();
        seen_len.delete();
        for (int i = 0; i < 5; i++) push_tx(8'(8'h20 + i));
        check("tx_full_ready", core_tx_ready, 1'b0);
        push_tx(8'h25);
        wait_seen(6, "tx_full_wait");
        if (seen_q.size() >= 6) begin
            for (int i = 0; i < 6; i++) check("tx_full_order", seen_q[i], 8'(8'h20 + i));
        end
        repeat (3) tick();

        // Reset in the middle of a strobe
        host_read = 1'b1;
        host_data = 8'h42;
        tick();
        host_read = 1'b0;
        push_tx(8'h77);
        push_tx(8'h88);
        begin
            int k = 0;
            while (!dev_write && k < 40) begin
                tick();
                k++;
            end
            check("mid_strobe_wait", k < 40, 1'b1);
        end
        rst = 1'b1;
        #1;
        check("arst_dev_write", dev_write, 1'b0);
        check("arst_dev_data", dev_data, 8'h00);
        check("arst_rx_valid", core_rx_valid, 1'b0);
        check("arst_tx_ready", core_tx_ready, 1'b1);
        check("arst_overflow", rx_overflow, 1'b0);
        tick();
        rst = 1'b0;
        seen_q.delete();
        repeat (20) tick();
        check("arst_no_tx", seen_q.size(), 0);

`ifdef CSOC_RESP_LOOPBACK_EN
        // Loopback echo
        seen_q.delete();
        seen_cyc.delete();
        seen_len.delete();
        loopback  = 1'b1;
        host_read = 1'b1;
        host_data = 8'h5A;
        #1;
        check("lb_core_blocked", core_tx_ready, 1'b0);
        tick();
        host_read = 1'b0;
        check("lb_rx_data", core_rx_data, 8'h5A);
        wait_seen(1, "lb_wait");
        if (seen_q.size() >= 1) check("lb_echo", seen_q[0], 8'h5A);
        loopback = 1'b0;
        repeat (5) tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/csoc_uart_responder.md
Name: csoc_uart_responder

Overview:
CSoC-side end of the tester byte interface. The tester pulses its read strobe with a byte, and this block accepts and buffers it for the CSoC core. The block also takes bytes from the core and returns them to the tester as timed write strobes with data. It sits on the CSoC (device) side and is clocked by the tester-supplied CSoC clock.

Parameters:
RX_DEPTH, 4, RX FIFO entries (power of 2, >=2)
TX_DEPTH, 4, TX FIFO entries (power of 2, >=2)
STROBE_CYCLES, 2, cycles dev_write is held high per byte (>=1)
GAP_CYCLES, 1, idle cycles after each strobe before the next setup (>=0)

Ports:
clk  in  1  CSoC clock
rst  in  1  reset, asynchronous, active-high
host_read  in  1  tester strobe; one cycle high = one byte on host_data
host_data  in  8  byte from tester, sampled when host_read=1
dev_write  out  1  strobe to tester; byte valid on dev_data
dev_data  out  8  byte to tester
core_rx_data  out  8  head of RX FIFO
core_rx_valid  out  1  RX FIFO not empty
core_rx_ready  in  1  core pops RX head when valid&ready
core_tx_data  in  8  byte from core
core_tx_valid  in  1  core push request
core_tx_ready  out  1  TX FIFO not full
rx_overflow  out  1  sticky: byte dropped because RX FIFO was full

Behaviour:
- Single clock domain. Async active-high rst clears all state.
- Reset values: dev_write=0, dev_data=0, core_rx_valid=0, core_rx_data=0, core_tx_ready=1, rx_overflow=0, both FIFOs empty, TX FSM in IDLE.
- host_read is a level sample, not edge detected. Each high cycle pushes one byte, so back-to-back high cycles push consecutive bytes.
- RX push when host_read=1 and RX not full. Data appears on core_rx_data/core_rx_valid on the next cycle (1-cycle latency). The FIFO head is registered, not fall-through.
- RX full with host_read=1: byte dropped, rx_overflow set next cycle, FIFO contents unchanged. rx_overflow clears only on rst.
- Simultaneous RX push and pop while full: pop frees a slot, push accepted, no overflow. Push and pop at any other occupancy: both take effect and occupancy is unchanged.
- TX push when core_tx_valid & core_tx_ready. Simultaneous push and pop while full: core_tx_ready=0 that cycle, so the push is not taken.
- Pointers wrap modulo depth. Occupancy counter width is clog2(depth)+1.
- TX FSM states:
  - IDLE: if TX not empty, pop the head into dev_data and go to SETUP.
  - SETUP: 1 cycle, dev_data stable, dev_write=0, then go to STROBE.
  - STROBE: dev_write=1 for STROBE_CYCLES cycles via a down-counter, dev_data stable, then go to GAP (GAP_CYCLES>0) or IDLE.
  - GAP: dev_write=0 for GAP_CYCLES cycles, then IDLE.
- dev_data holds the last byte sent after STROBE ends, until the next SETUP.
- Minimum byte period = 1(IDLE)+1+STROBE_CYCLES+GAP_CYCLES cycles. With defaults this is 5.
- rst asserted mid-STROBE: dev_write drops immediately (async). The byte in flight and all queued bytes are discarded.

Optional Feature:
CSOC_RESP_LOOPBACK_EN
- Defined: extra input port loopback (1 bit). When loopback=1, each accepted RX byte is also pushed into the TX FIFO, provided TX is not full, and is echoed to the tester. The core TX push is blocked that cycle: core_tx_ready=0 whenever host_read=1. A byte lost to TX full is not flagged. Bytes still enter the RX FIFO.
- Undefined: no loopback port, TX FIFO fed only by the core.

Test Plan:
- Reset: assert rst mid-sim -> dev_write=0, core_rx_valid=0, core_tx_ready=1, rx_overflow=0 within the same cycle.
- RX basic: host_read 1 cycle with 0xA5, core_rx_ready=0 -> next cycle core_rx_valid=1, core_rx_data=0xA5. Hold ready 1 cycle -> valid=0.
- RX overflow: 5 consecutive host_read bytes 0x01..0x05 with core_rx_ready=0 (RX_DEPTH=4) -> rx_overflow=1. Popping yields 0x01..0x04 only.
- TX timing: push 0x3C then 0xC3 back-to-back -> dev_write high 2 cycles with dev_data=0x3C. Next rising edge of dev_write is exactly 5 cycles after the first, with dev_data=0xC3.
- TX full: push 5 bytes with the FSM busy -> core_tx_ready=0 after the 4th occupancy. No byte lost, order preserved.
- Loopback (macro defined, loopback=1): host_read 0x5A -> core_rx_data=0x5A, and a dev_write strobe carrying 0x5A follows.
